fifo_word_reader: RTL

- Read-side drain engine for the byte-wide dual-clock FIFO; lives entirely in the rd_clk domain.
- Pops bytes through the FIFO read port (rd_en / data_out / empty) and packs BYTES_PER_WORD bytes into one word.
- Presents each word on a valid/ready stream to downstream logic.
- A flush request emits a final partial word tagged with its byte count.

---
 rtl/fifo_word_reader_if.sv | 13 +
 rtl/fifo_word_reader.sv | 64 ++++++
 2 files changed

// File: rtl/fifo_word_reader_if.sv
// fifo_word_reader_if: packed-word valid/ready stream (m_data, m_valid, m_bytes, m_last out of master; m_ready into master)
interface fifo_word_reader_if #(
  parameter int DATA_W = 8,
  parameter int BYTES_PER_WORD = 2
);
  logic [DATA_W*BYTES_PER_WORD-1:0] m_data;
  logic m_valid;
  logic m_ready;
  logic [3:0] m_bytes;
  logic m_last;
  modport master(output m_data, m_valid, m_bytes, m_last, input m_ready);
  modport slave(input m_data, m_valid, m_bytes, m_last, output m_ready);
endinterface

// File: rtl/fifo_word_reader.sv
// fifo_word_reader: drains byte FIFO (fifo_rd_en/fifo_rdata/fifo_empty) into words on stream m, flush emits partial word; byte_count/busy status; rd_clk, sync rst
module fifo_word_reader #(
  parameter int DATA_W = 8,
  parameter int BYTES_PER_WORD = 2,
  parameter int COUNT_W = 16
) (
  input  logic rd_clk,
  input  logic rst,
  input  logic en,
  input  logic fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic fifo_rd_en,
  input  logic flush,
  fifo_word_reader_if.master m,
  output logic [COUNT_W-1:0] byte_count,
  output logic busy
);
  localparam int WW = DATA_W * BYTES_PER_WORD;
  localparam logic [3:0] BPW = 4'(BYTES_PER_WORD);
  logic [WW-1:0] acc, acc_n;
  logic [3:0] acc_cnt, cnt_n;
  logic pend, flush_req, free, flush_done, emit_flush, emit_full;
  always_comb begin
    acc_n = acc;
    for (int i = 0; i < BYTES_PER_WORD; i++)
      if (pend && acc_cnt == 4'(i)) acc_n[i*DATA_W +: DATA_W] = fifo_rdata;
    cnt_n = acc_cnt + {3'b0, pend};
    free = !m.m_valid || m.m_ready;
    flush_done = flush_req && !pend && free;
    emit_flush = flush_done && acc_cnt != 4'd0;
    emit_full = free && cnt_n == BPW && !emit_flush;
    fifo_rd_en = !rst && en && !fifo_empty && !flush_req && cnt_n < BPW;
  end
  assign busy = acc_cnt != 4'd0 || pend || flush_req || m.m_valid;
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      acc <= '0;
      acc_cnt <= '0;
      pend <= 1'b0;
      flush_req <= 1'b0;
      byte_count <= '0;
      m.m_data <= '0;
      m.m_valid <= 1'b0;
      m.m_bytes <= '0;
      m.m_last <= 1'b0;
    end else begin
      pend <= fifo_rd_en;
      byte_count <= byte_count + COUNT_W'(fifo_rd_en);
      flush_req <= flush_req ? !flush_done : flush;
      if (emit_flush || emit_full) begin
        acc <= '0;
        acc_cnt <= '0;
        m.m_data <= acc_n;
        m.m_valid <= 1'b1;
        m.m_bytes <= emit_full ? BPW : acc_cnt;
        m.m_last <= emit_flush;
      end else begin
        acc <= acc_n;
        acc_cnt <= cnt_n;
        if (m.m_ready) m.m_valid <= 1'b0;
      end
    end
  end
endmodule
